mult_controller: RTL and testbench



---
 rtl/mult_controller_if.sv | 23 ++
 rtl/mult_controller.sv | 60 ++++++
 tb/tb_mult_controller.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mult_controller_if.sv
// Handshake and datapath-control bundle between the multiplier controller
// and its surroundings (input source and 4x4 multiplier datapath).
interface mult_controller_if;
    logic start;
    logic ld_1;
    logic ld_2;
    logic s0;
    logic s1;
    logic s2;
    logic clr_acc;
    logic busy;
    logic done;

    modport master (
        output start,
        input  ld_1, ld_2, s0, s1, s2, clr_acc, busy, done
    );

    modport slave (
        input  start,
        output ld_1, ld_2, s0, s1, s2, clr_acc, busy, done
    );
endinterface

// File: rtl/mult_controller.sv
// Moore control FSM for the 4x4 digit-serial multiplier: sequences the four
// 2x2 partial products (HH, HL, LH, LL) into the shift-accumulate datapath.
module mult_controller (
    input  logic              clk,
    input  logic              rst,
    mult_controller_if.slave  m
);
    localparam int unsigned CTRL_W = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        P_HH = 3'd2,
        P_HL = 3'd3,
        P_LH = 3'd4,
        P_LL = 3'd5,
        DONE = 3'd6
    } state_t;

    state_t state;

    function automatic state_t next_of(input state_t s, input logic go);
        case (s)
            IDLE:    next_of = go ? LOAD : IDLE;
            LOAD:    next_of = P_HH;
            P_HH:    next_of = P_HL;
            P_HL:    next_of = P_LH;
            P_LH:    next_of = P_LL;
            P_LL:    next_of = DONE;
            DONE:    next_of = go ? LOAD : IDLE;
            default: next_of = IDLE;
        endcase
    endfunction

    // Output word: {ld_1, ld_2, s0, s1, s2, clr_acc, busy, done}
    function automatic logic [CTRL_W-1:0] decode(input state_t s);
        case (s)
            LOAD:    decode = 8'b1000_0110;
            P_HH:    decode = 8'b0111_1010;
            P_HL:    decode = 8'b0110_0010;
            P_LH:    decode = 8'b0101_1010;
            P_LL:    decode = 8'b0100_0010;
            DONE:    decode = 8'b0000_0001;
            default: decode = 8'b0000_0000;
        endcase
    endfunction

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            {m.ld_1, m.ld_2, m.s0, m.s1, m.s2, m.clr_acc, m.busy, m.done}
                <= CTRL_W'(0);
        end else begin
            state <= next_of(state, m.start);
            {m.ld_1, m.ld_2, m.s0, m.s1, m.s2, m.clr_acc, m.busy, m.done}
                <= decode(next_of(state, m.start));
        end
    end
endmodule

// File: tb/tb_mult_controller.sv
// Directed bench for mult_controller with a small behavioural model of the
// 4x4 shift-accumulate datapath it drives.
module tb_mult_controller;
    logic clk;
    logic rst;
    mult_controller_if bus();

    mult_controller dut (
        .clk (clk),
        .rst (rst),
        .m   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath model: operand registers, 2x2 multiplier, accumulator.
    logic [3:0] op_a, op_b, ra, rb;
    logic [1:0] da, db;
    logic [3:0] prod;
    logic [7:0] acc, acc_next;

    always_comb begin
        da       = bus.s0 ? ra[3:2] : ra[1:0];
        db       = bus.s1 ? rb[3:2] : rb[1:0];
        prod     = {2'b00, da} * {2'b00, db};
        acc_next = (bus.s2 ? acc : {acc[5:0], 2'b00}) + {4'b0000, prod};
    end

    always_ff @(posedge clk) begin
        if (bus.ld_1) begin
            ra <= op_a;
            rb <= op_b;
        end
        if (bus.clr_acc)   acc <= 8'd0;
        else if (bus.ld_2) acc <= acc_next;
    end

    logic [7:0] ctrl;
    assign ctrl = {bus.ld_1, bus.ld_2, bus.s0, bus.s1, bus.s2,
                   bus.clr_acc, bus.busy, bus.done};

    typedef struct packed {
        logic [3:0]       a;
        logic [3:0]       b;
        logic [3:0][7:0]  steps;   // steps[0] = acc after P_HH ... steps[3] = product
    } vec_t;

    vec_t       vecs [6];
    logic [7:0] exp_ctrl [6];
    int         n_checks;
    int         n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One full operation: start pulsed for one cycle, then LOAD..DONE checked cycle by cycle.
    task automatic run_op(input vec_t v, input string tag);
        bus.start = 1'b1;
        op_a = v.a;
        op_b = v.b;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (k == 2) begin
                op_a = ~v.a;
                op_b = 4'(v.b + 4'd1);
            end
            check($sformatf("%s ctrl c%0d", tag, k), 32'(ctrl), 32'(exp_ctrl[k-1]));
            if (k >= 3)
                check($sformatf("%s acc c%0d", tag, k), 32'(acc), 32'(v.steps[k-3]));
        end
        @(posedge clk); #1;
        check($sformatf("%s idle after", tag), 32'(ctrl), 32'd0);
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;
        n_checks = 0;
        n_fail   = 0;

        exp_ctrl[0] = 8'b1000_0110;   // LOAD
        exp_ctrl[1] = 8'b0111_1010;   // P_HH
        exp_ctrl[2] = 8'b0110_0010;   // P_HL
        exp_ctrl[3] = 8'b0101_1010;   // P_LH
        exp_ctrl[4] = 8'b0100_0010;   // P_LL
        exp_ctrl[5] = 8'b0000_0001;   // DONE

        vecs[0] = '{a: 4'd13, b: 4'd6,  steps: {8'd78,  8'd19, 8'd18, 8'd3}};
        vecs[1] = '{a: 4'd15, b: 4'd15, steps: {8'd225, 8'd54, 8'd45, 8'd9}};
        vecs[2] = '{a: 4'd0,  b: 4'd9,  steps: {8'd0,   8'd0,  8'd0,  8'd0}};
        vecs[3] = '{a: 4'd9,  b: 4'd0,  steps: {8'd0,   8'd0,  8'd0,  8'd0}};
        vecs[4] = '{a: 4'd2,  b: 4'd3,  steps: {8'd6,   8'd0,  8'd0,  8'd0}};
        vecs[5] = '{a: 4'd7,  b: 4'd9,  steps: {8'd63,  8'd15, 8'd9,  8'd2}};

        rst = 1'b1;
        bus.start = 1'b0;
        op_a = 4'd0;
        op_b = 4'd0;
        #1;
        check("reset outputs", 32'(ctrl), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle after reset", 32'(ctrl), 32'd0);

        // Single operations, including zero operands right after 15x15.
        for (int i = 0; i < 4; i++)
            run_op(vecs[i], $sformatf("vec%0d", i));

        // start held high: 3x5 then 10x7 back to back, never through IDLE.
        bus.start = 1'b1;
        op_a = 4'd3;
        op_b = 4'd5;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (c == 2) begin
                op_a = 4'd10;
                op_b = 4'd7;
            end
            check($sformatf("hold done c%0d", c), 32'(bus.done), 32'(c % 6 == 0));
            check($sformatf("hold busy c%0d", c), 32'(bus.busy), 32'(c % 6 != 0));
            if (c == 6)  check("hold out 3x5",  32'(acc), 32'd15);
            if (c == 12) begin
                check("hold out 10x7", 32'(acc), 32'd70);
                bus.start = 1'b0;
            end
        end
        @(posedge clk); #1;
        check("hold idle after", 32'(ctrl), 32'd0);

        // Asynchronous reset in P_HL aborts the operation with no done.
        bus.start = 1'b1;
        op_a = 4'd5;
        op_b = 4'd5;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        check("pre-abort in P_HL", 32'(ctrl), 32'(exp_ctrl[2]));
        #2 rst = 1'b1;
        #1;
        check("async reset outputs", 32'(ctrl), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            check($sformatf("post-abort idle c%0d", k), 32'(ctrl), 32'd0);
        end
        run_op(vecs[4], "after-abort 2x3");

        // start pulses in P_HH, P_LH, P_LL are ignored.
        busy_cnt = 0;
        done_cnt = 0;
        bus.start = 1'b1;
        op_a = vecs[5].a;
        op_b = vecs[5].b;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            bus.start = (k == 2 || k == 4 || k == 5);
            if (bus.busy) busy_cnt++;
            if (bus.done) done_cnt++;
            if (k <= 6)
                check($sformatf("ignore ctrl c%0d", k), 32'(ctrl), 32'(exp_ctrl[k-1]));
            else
                check($sformatf("ignore idle c%0d", k), 32'(ctrl), 32'd0);
            if (k == 6) check("ignore out 7x9", 32'(acc), 32'd63);
        end
        check("ignore busy count", 32'(busy_cnt), 32'd5);
        check("ignore done count", 32'(done_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
